top_proc_core: RTL and testbench
================================

Name: top_proc_core

Overview:
- Multicycle RV32I-subset processor core. Five one-cycle states per instruction: IF, ID, EX, MEM, WB.
- Fetches from an external synchronous instruction ROM and loads/stores through an external synchronous data RAM.
- Sits between the instruction and data memory blocks at the top of the design.
- Contains the FSM control unit, datapath, ALU and register file.

Parameters:
- INITIAL_PC, 32'h00400000, PC value loaded on reset.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- instr  in  32  instruction word from ROM; valid one cycle after PC is presented.
- dReadData  in  32  RAM read data; valid one cycle after dAddress is presented.
- PC  out  32  registered program counter, drives ROM address.
- dAddress  out  32  data address (ALU result).
- dWriteData  out  32  store data (rs2 value).
- MemRead  out  1  high only in MEM for LW.
- MemWrite  out  1  high only in MEM for SW.
- WriteBackData  out  32  value written to rd: dReadData for LW, else ALU result.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=INITIAL_PC, FSM=IF, MemRead=0, MemWrite=0.
  - Register file cleared to 0.
  - Reset mid-instruction aborts it; no register or memory write may occur.
- FSM sequence: IF->ID->EX->MEM->WB->IF, unconditional, every instruction takes exactly 5 cycles.
  - IF: PC presented to ROM.
  - ID: instr decoded, rs1/rs2 read (combinational), immediate generated.
  - EX: ALU evaluates.
  - MEM: MemRead/MemWrite asserted per opcode.
  - WB: rd written, PC updated.
- PC update in WB only:
  - BEQ with rs1==rs2: PC += B-immediate (sign-extended, bit0=0).
  - Otherwise: PC += 4, 32-bit wrap-around.
- Supported instructions:
  - R-type: ADD SUB AND OR XOR SLT SLL SRL SRA.
  - I-type: ADDI ANDI ORI XORI SLTI SLLI SRLI SRAI.
  - Memory and branch: LW, SW, BEQ.
  - Any other opcode or funct combination is a NOP: no writes, PC+4.
- ALU rules:
  - 32-bit, 4-bit control code.
  - SLT/SLTI: signed compare, result 0 or 1.
  - Shifts use the low 5 bits of operand B; SRA/SRAI are arithmetic.
  - Zero flag = (result==0), used for BEQ via SUB.
  - Overflow ignored.
- Immediates: I, S and B formats, sign-extended to 32 bits.
- Register file:
  - 32x32, two combinational read ports, one write port.
  - Write occurs on the WB edge when RegWrite=1 (R-type, I-type ALU, LW).
  - x0 always reads 0; writes to x0 are discarded.
- dAddress = rs1 + imm for LW/SW, held stable through MEM.
- dWriteData = rs2, held through MEM.
- WriteBackData is combinational and is meaningful in WB.

Decomposition:
- Shared package holds:
  - opcode constants (R=0110011, I=0010011, LW=0000011, SW=0100011, BEQ=1100011);
  - ALU control codes;
  - FSM state encoding.
- Natural sub-modules: core_alu, plus regfile and datapath inside the core.
- Companion memory blocks are separate modules:
  - data_memory: 128x32, sync write when we=1, sync read, word index = addr[8:2].
  - instruction_memory: 128x32 ROM, sync read, word index = addr[8:2], initialised from file.

Test Plan:
- Reset then ADDI x1,x0,5 at 0x00400000 -> WB cycle: WriteBackData=5; after WB: PC=0x00400004; x1=5.
- ADDI x2,x0,-3; SUB x3,x1,x2 -> x3=8; SLT x4,x2,x1 -> x4=1; SRA of 0x80000000 by 4 -> 0xF8000000.
- SW x1,8(x0) then LW x5,8(x0):
  - SW MEM cycle: MemWrite=1, dAddress=8, dWriteData=5.
  - LW MEM cycle: MemRead=1.
  - LW WB cycle: WriteBackData=5, x5=5.
- BEQ x1,x1,+12 at PC P -> next PC=P+12. BEQ x1,x2,+12 -> next PC=P+4.
- ADDI x0,x0,7 -> x0 still reads 0. Undefined opcode 0x00000000 -> no MemWrite, PC+4.
- Assert rst low during MEM of an SW -> MemWrite drops immediately, RAM unchanged, PC=0x00400000, FSM=IF.

Source files
------------

// File: rtl/top_proc_core_pkg.sv
// Shared definitions for the multicycle RV32I-subset core.
// Holds the opcodes, ALU codes, FSM encoding and the instruction decoder.
package top_proc_core_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [1:0] B_REG  = 2'd0;
    localparam logic [1:0] B_IMMI = 2'd1;
    localparam logic [1:0] B_IMMS = 2'd2;

    typedef struct packed {
        logic [3:0] aluCtrl;
        logic [1:0] bSel;
        logic       regWrite;
        logic       isLoad;
        logic       isStore;
        logic       isBranch;
    } CtrlSignals;

    // Unsupported opcode/funct combinations fall through as all-zero controls, i.e. a NOP.
    function automatic CtrlSignals decodeInstr(input logic [6:0] opcode,
                                               input logic [2:0] funct3,
                                               input logic [6:0] funct7);
        CtrlSignals c;
        c = '0;
        case (opcode)
            OP_R: begin
                c.regWrite = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: c.aluCtrl = ALU_ADD;
                    {7'b0100000, 3'b000}: c.aluCtrl = ALU_SUB;
                    {7'b0000000, 3'b111}: c.aluCtrl = ALU_AND;
                    {7'b0000000, 3'b110}: c.aluCtrl = ALU_OR;
                    {7'b0000000, 3'b100}: c.aluCtrl = ALU_XOR;
                    {7'b0000000, 3'b010}: c.aluCtrl = ALU_SLT;
                    {7'b0000000, 3'b001}: c.aluCtrl = ALU_SLL;
                    {7'b0000000, 3'b101}: c.aluCtrl = ALU_SRL;
                    {7'b0100000, 3'b101}: c.aluCtrl = ALU_SRA;
                    default:              c.regWrite = 1'b0;
                endcase
            end
            OP_I: begin
                c.regWrite = 1'b1;
                c.bSel     = B_IMMI;
                case (funct3)
                    3'b000: c.aluCtrl = ALU_ADD;
                    3'b111: c.aluCtrl = ALU_AND;
                    3'b110: c.aluCtrl = ALU_OR;
                    3'b100: c.aluCtrl = ALU_XOR;
                    3'b010: c.aluCtrl = ALU_SLT;
                    3'b001: begin
                        c.aluCtrl  = ALU_SLL;
                        c.regWrite = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        c.aluCtrl  = (funct7[5]) ? ALU_SRA : ALU_SRL;
                        c.regWrite = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: c.regWrite = 1'b0;
                endcase
            end
            OP_LW: begin
                if (funct3 == 3'b010) begin
                    c.regWrite = 1'b1;
                    c.isLoad   = 1'b1;
                    c.bSel     = B_IMMI;
                end
            end
            OP_SW: begin
                if (funct3 == 3'b010) begin
                    c.isStore = 1'b1;
                    c.bSel    = B_IMMS;
                end
            end
            OP_BEQ: begin
                if (funct3 == 3'b000) begin
                    c.isBranch = 1'b1;
                    c.aluCtrl  = ALU_SUB;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/top_proc_core_alu.sv
// 32-bit ALU for the multicycle core; zero flag drives BEQ through SUB.
module top_proc_core_alu
    import top_proc_core_pkg::*;
(
    input  logic [3:0]  aluCtrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (aluCtrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/top_proc_core.sv
// Multicycle RV32I-subset core: IF/ID/EX/MEM/WB FSM, register file and datapath.
// Instruction and data memories are external synchronous blocks.
module top_proc_core
    import top_proc_core_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] dReadData,
    output logic [31:0] PC,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] WriteBackData
);

    logic [2:0]  state;
    logic [31:0] regs [32];
    logic [31:0] regA, regB, aluOut, aluB, aluResult;
    logic [31:0] immI, immS, immB, rs1Val, rs2Val;
    logic        aluZero, zeroFlag;
    logic [4:0]  rs1, rs2, rd;
    CtrlSignals  ctrl;

    // The ROM keeps reading the unchanged PC until WB, so instr stays valid from ID to WB.
    assign ctrl = decodeInstr(instr[6:0], instr[14:12], instr[31:25]);
    assign rs1  = instr[19:15];
    assign rs2  = instr[24:20];
    assign rd   = instr[11:7];
    assign immI = {{20{instr[31]}}, instr[31:20]};
    assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    assign rs1Val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2Val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF:    state <= S_ID;
                S_ID:    state <= S_EX;
                S_EX:    state <= S_MEM;
                S_MEM:   state <= S_WB;
                default: state <= S_IF;
            endcase
        end
    end

    always_comb begin
        aluB = regB;
        case (ctrl.bSel)
            B_IMMI:  aluB = immI;
            B_IMMS:  aluB = immS;
            default: aluB = regB;
        endcase
    end

    top_proc_core_alu uAlu (
        .aluCtrl (ctrl.aluCtrl),
        .a       (regA),
        .b       (aluB),
        .result  (aluResult),
        .zero    (aluZero)
    );

    // Operands latch at the end of ID and the ALU result at the end of EX, so dAddress holds through MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regA     <= '0;
            regB     <= '0;
            aluOut   <= '0;
            zeroFlag <= 1'b0;
        end else begin
            if (state == S_ID) begin
                regA <= rs1Val;
                regB <= rs2Val;
            end
            if (state == S_EX) begin
                aluOut   <= aluResult;
                zeroFlag <= aluZero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC <= INITIAL_PC;
        end else if (state == S_WB) begin
            PC <= (ctrl.isBranch && zeroFlag) ? PC + immB : PC + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (state == S_WB && ctrl.regWrite && rd != 5'd0) begin
            regs[rd] <= WriteBackData;
        end
    end

    assign MemRead       = (state == S_MEM) && ctrl.isLoad;
    assign MemWrite      = (state == S_MEM) && ctrl.isStore;
    assign dAddress      = aluOut;
    assign dWriteData    = regB;
    assign WriteBackData = ctrl.isLoad ? dReadData : aluOut;

endmodule

// File: tb/tb_top_proc_core.sv
// Self-checking bench for top_proc_core with behavioural ROM/RAM and a scoreboard of expected results.
module tb_top_proc_core;

    localparam logic [31:0] INIT_PC = 32'h00400000;
    localparam logic [6:0]  OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LW = 7'b0000011;

    typedef struct {
        logic [31:0] expWb;
        logic [31:0] expPc;
        logic        expRd;
        logic        expWr;
        logic [31:0] expAddr;
        logic [31:0] expData;
    } ExpRec;

    logic        clk, rst;
    logic [31:0] instr, dReadData, PC, dAddress, dWriteData, WriteBackData;
    logic        MemRead, MemWrite;
    logic [31:0] rom [128];
    logic [31:0] ram [128];
    ExpRec       sb [$];
    int          checkCount, passCount;

    top_proc_core #(.INITIAL_PC(INIT_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .dReadData     (dReadData),
        .PC            (PC),
        .dAddress      (dAddress),
        .dWriteData    (dWriteData),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .WriteBackData (WriteBackData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM and RAM models: data appears one cycle after the address
    always @(posedge clk) begin
        instr <= rom[PC[8:2]];
        if (MemWrite) ram[dAddress[8:2]] <= dWriteData;
        dReadData <= ram[dAddress[8:2]];
    end

    function automatic logic [31:0] encR(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_R};
    endfunction

    function automatic logic [31:0] encI(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] pcOf(int idx);
        return INIT_PC + 32'(idx * 4);
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < 128; i++) begin
            rom[i] = 32'd0;
            ram[i] = 32'd0;
        end
        rom[0]  = encI(12'd5, 5'd0, 3'b000, 5'd1, OPC_I);
        rom[1]  = encI(-12'sd3, 5'd0, 3'b000, 5'd2, OPC_I);
        rom[2]  = encR(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
        rom[3]  = encR(7'b0000000, 5'd1, 5'd2, 3'b010, 5'd4);
        rom[4]  = encI(12'd1, 5'd0, 3'b000, 5'd7, OPC_I);
        rom[5]  = encI({7'b0000000, 5'd31}, 5'd7, 3'b001, 5'd7, OPC_I);
        rom[6]  = encI({7'b0100000, 5'd4}, 5'd7, 3'b101, 5'd8, OPC_I);
        rom[7]  = encI({7'b0000000, 5'd4}, 5'd7, 3'b101, 5'd11, OPC_I);
        rom[8]  = encR(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd12);
        rom[9]  = encR(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd13);
        rom[10] = encI(12'h00F, 5'd2, 3'b111, 5'd14, OPC_I);
        rom[11] = encI(-12'sd2, 5'd2, 3'b010, 5'd15, OPC_I);
        rom[12] = encS(12'd8, 5'd1, 5'd0);
        rom[13] = encI(12'd8, 5'd0, 3'b010, 5'd5, OPC_LW);
        rom[14] = encB(13'd12, 5'd1, 5'd1);
        rom[15] = encI(12'd99, 5'd0, 3'b000, 5'd20, OPC_I);
        rom[16] = encI(12'd99, 5'd0, 3'b000, 5'd20, OPC_I);
        rom[17] = encB(13'd12, 5'd2, 5'd1);
        rom[18] = encI(12'd7, 5'd0, 3'b000, 5'd0, OPC_I);
        rom[19] = encR(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd6);
        rom[20] = 32'h00000000;
        rom[21] = encR(7'b0000000, 5'd3, 5'd5, 3'b000, 5'd16);
        rom[22] = encS(12'd12, 5'd1, 5'd0);
    endtask

    // Advance one five-cycle instruction from mid-IF, capturing MEM, WB and next-IF observations
    task automatic checkOutput(output logic mRd, output logic mWr, output logic [31:0] mAddr,
                               output logic [31:0] mData, output logic [31:0] wb,
                               output logic [31:0] pcNext);
        repeat (3) @(posedge clk);
        @(negedge clk);
        mRd   = MemRead;
        mWr   = MemWrite;
        mAddr = dAddress;
        mData = dWriteData;
        @(posedge clk);
        @(negedge clk);
        wb = WriteBackData;
        @(posedge clk);
        @(negedge clk);
        pcNext = PC;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (PC !== INIT_PC) $display("[TB] FAIL reset_pc: got %h expected %h", PC, INIT_PC);
        else passCount++;
        checkCount++;
        if ({MemRead, MemWrite} !== 2'b00)
            $display("[TB] FAIL reset_mem_ctrl: got %b expected 00", {MemRead, MemWrite});
        else passCount++;
        rst = 1'b1;
    endtask

    task automatic test_alu();
        logic [31:0] wbTab [12] = '{32'd5, 32'hFFFFFFFD, 32'd8, 32'd1, 32'd1, 32'h80000000,
                                    32'hF8000000, 32'h08000000, 32'hFFFFFFF8, 32'hFFFFFFFD,
                                    32'h0000000D, 32'd1};
        logic        mRd, mWr;
        logic [31:0] mAddr, mData, wb, pcNext;
        ExpRec       e;
        for (int i = 0; i < 12; i++) begin
            e = '{expWb: wbTab[i], expPc: pcOf(i + 1), expRd: 1'b0, expWr: 1'b0,
                  expAddr: 32'd0, expData: 32'd0};
            sb.push_back(e);
        end
        for (int i = 0; i < 12; i++) begin
            checkOutput(mRd, mWr, mAddr, mData, wb, pcNext);
            e = sb.pop_front();
            checkCount++;
            if (wb !== e.expWb) $display("[TB] FAIL alu_wb[%0d]: got %h expected %h", i, wb, e.expWb);
            else passCount++;
            checkCount++;
            if (pcNext !== e.expPc) $display("[TB] FAIL alu_pc[%0d]: got %h expected %h", i, pcNext, e.expPc);
            else passCount++;
            checkCount++;
            if ({mRd, mWr} !== {e.expRd, e.expWr})
                $display("[TB] FAIL alu_memctrl[%0d]: got %b expected %b", i, {mRd, mWr}, {e.expRd, e.expWr});
            else passCount++;
        end
    endtask

    task automatic test_memory();
        logic        mRd, mWr;
        logic [31:0] mAddr, mData, wb, pcNext;
        ExpRec       e;
        sb.push_back('{expWb: 32'd0, expPc: pcOf(13), expRd: 1'b0, expWr: 1'b1, expAddr: 32'd8, expData: 32'd5});
        sb.push_back('{expWb: 32'd5, expPc: pcOf(14), expRd: 1'b1, expWr: 1'b0, expAddr: 32'd8, expData: 32'd0});
        for (int i = 0; i < 2; i++) begin
            checkOutput(mRd, mWr, mAddr, mData, wb, pcNext);
            e = sb.pop_front();
            checkCount++;
            if ({mRd, mWr} !== {e.expRd, e.expWr})
                $display("[TB] FAIL mem_ctrl[%0d]: got %b expected %b", i, {mRd, mWr}, {e.expRd, e.expWr});
            else passCount++;
            checkCount++;
            if (mAddr !== e.expAddr) $display("[TB] FAIL mem_addr[%0d]: got %h expected %h", i, mAddr, e.expAddr);
            else passCount++;
            checkCount++;
            if (pcNext !== e.expPc) $display("[TB] FAIL mem_pc[%0d]: got %h expected %h", i, pcNext, e.expPc);
            else passCount++;
            if (e.expWr) begin
                checkCount++;
                if (mData !== e.expData) $display("[TB] FAIL sw_data: got %h expected %h", mData, e.expData);
                else passCount++;
            end else begin
                checkCount++;
                if (wb !== e.expWb) $display("[TB] FAIL lw_wb: got %h expected %h", wb, e.expWb);
                else passCount++;
            end
        end
        checkCount++;
        if (ram[2] !== 32'd5) $display("[TB] FAIL ram_word2: got %h expected %h", ram[2], 32'd5);
        else passCount++;
    endtask

    task automatic test_branch();
        logic        mRd, mWr;
        logic [31:0] mAddr, mData, wb, pcNext;
        ExpRec       e;
        sb.push_back('{expWb: 32'd0, expPc: pcOf(14) + 32'd12, expRd: 1'b0, expWr: 1'b0, expAddr: 32'd0, expData: 32'd0});
        sb.push_back('{expWb: 32'd0, expPc: pcOf(17) + 32'd4, expRd: 1'b0, expWr: 1'b0, expAddr: 32'd0, expData: 32'd0});
        for (int i = 0; i < 2; i++) begin
            checkOutput(mRd, mWr, mAddr, mData, wb, pcNext);
            e = sb.pop_front();
            checkCount++;
            if (pcNext !== e.expPc) $display("[TB] FAIL beq_pc[%0d]: got %h expected %h", i, pcNext, e.expPc);
            else passCount++;
        end
    endtask

    task automatic test_x0_nop();
        logic        mRd, mWr;
        logic [31:0] mAddr, mData, wb, pcNext;
        ExpRec       e;
        sb.push_back('{expWb: 32'd7,  expPc: pcOf(19), expRd: 1'b0, expWr: 1'b0, expAddr: 32'd0, expData: 32'd0});
        sb.push_back('{expWb: 32'd0,  expPc: pcOf(20), expRd: 1'b0, expWr: 1'b0, expAddr: 32'd0, expData: 32'd0});
        sb.push_back('{expWb: 32'd0,  expPc: pcOf(21), expRd: 1'b0, expWr: 1'b0, expAddr: 32'd0, expData: 32'd0});
        sb.push_back('{expWb: 32'd13, expPc: pcOf(22), expRd: 1'b0, expWr: 1'b0, expAddr: 32'd0, expData: 32'd0});
        for (int i = 0; i < 4; i++) begin
            checkOutput(mRd, mWr, mAddr, mData, wb, pcNext);
            e = sb.pop_front();
            checkCount++;
            if (pcNext !== e.expPc) $display("[TB] FAIL x0nop_pc[%0d]: got %h expected %h", i, pcNext, e.expPc);
            else passCount++;
            checkCount++;
            if ({mRd, mWr} !== 2'b00) $display("[TB] FAIL x0nop_memctrl[%0d]: got %b expected 00", i, {mRd, mWr});
            else passCount++;
            if (i != 0) begin
                checkCount++;
                if (wb !== e.expWb) $display("[TB] FAIL x0nop_wb[%0d]: got %h expected %h", i, wb, e.expWb);
                else passCount++;
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic        mRd, mWr;
        logic [31:0] mAddr, mData, wb, pcNext;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if (MemWrite !== 1'b1) $display("[TB] FAIL sw2_memwrite: got %b expected 1", MemWrite);
        else passCount++;
        rst = 1'b0;
        #1;
        checkCount++;
        if (MemWrite !== 1'b0) $display("[TB] FAIL abort_memwrite: got %b expected 0", MemWrite);
        else passCount++;
        checkCount++;
        if (PC !== INIT_PC) $display("[TB] FAIL abort_pc: got %h expected %h", PC, INIT_PC);
        else passCount++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (ram[3] !== 32'd0) $display("[TB] FAIL abort_ram: got %h expected %h", ram[3], 32'd0);
        else passCount++;
        rst = 1'b1;
        checkOutput(mRd, mWr, mAddr, mData, wb, pcNext);
        checkCount++;
        if (wb !== 32'd5) $display("[TB] FAIL restart_wb: got %h expected %h", wb, 32'd5);
        else passCount++;
        checkCount++;
        if (pcNext !== pcOf(1)) $display("[TB] FAIL restart_pc: got %h expected %h", pcNext, pcOf(1));
        else passCount++;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b0;
        applyStimulus();
        test_reset();
        test_alu();
        test_memory();
        test_branch();
        test_x0_nop();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
